bcd_key_entry: RTL and testbench

- Sits directly downstream of the 10-key decimal priority encoder.
- Consumes that encoder's 4-bit BCD code and its key-valid flag.
- Debounces the key-valid/code pair and accepts exactly one digit per physical press.
- Shifts accepted digits into an NDIG-digit BCD entry register, with count, full and overflow status, for display and compare stages further downstream.

---
 rtl/bcd_key_entry.sv | 156 +++++++++++++++
 tb/tb_bcd_key_entry.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bcd_key_entry.sv
// bcd_key_entry: debounces the key-valid/BCD code pair coming from the
// decimal priority encoder and accepts one digit per physical press. Accepted
// digits shift into an NDIG-digit BCD entry register with count/full/ovf status.
module bcd_key_entry #(
    parameter int DEB_CYCLES = 4,   // stable samples to accept a press or release (2..255)
    parameter int NDIG       = 4    // BCD digits held in the entry register (1..8)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                chk,
    input  logic [3:0]          digit,
    input  logic                clr,
    output logic [4*NDIG-1:0]   entry,
    output logic [3:0]          count,
    output logic                full,
    output logic                ovf,
    output logic                key_strobe
);

    localparam logic [7:0] DEB_C  = 8'(DEB_CYCLES);
    localparam logic [3:0] NDIG_C = 4'(NDIG);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          scnt_q, scnt_d;
    logic [7:0]          scnt_inc;
    logic [3:0]          kcode_q, kcode_d;
    logic                valid;
    logic                accept;

    logic [4*NDIG-1:0]   entry_q, entry_d;
    logic [4*NDIG-1:0]   kcode_ext;
    logic [3:0]          count_q, count_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic                strobe_q;

    // A code above 9 cannot come from a real key, so it reads as "no key".
    assign valid    = chk && (digit <= 4'd9);
    assign scnt_inc = scnt_q + 8'd1;

    // Debounce FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            scnt_q  <= 8'd0;
            kcode_q <= 4'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            kcode_q <= kcode_d;
        end
    end

    // Debounce next state; accept fires once, on the press-stable edge only.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        kcode_d = kcode_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = PRESS_WAIT;
                    scnt_d  = 8'd1;
                    kcode_d = digit;
                end
            end
            PRESS_WAIT: begin
                if (!valid) begin
                    state_d = IDLE;
                end else if (digit != kcode_q) begin
                    // Code moved mid-press: restart stability on the new code.
                    scnt_d  = 8'd1;
                    kcode_d = digit;
                end else begin
                    scnt_d = scnt_inc;
                    if (scnt_inc == DEB_C) begin
                        state_d = HELD;
                        accept  = 1'b1;
                    end
                end
            end
            HELD: begin
                // Any key (even a different one) keeps us here until a release.
                if (!valid) begin
                    state_d = REL_WAIT;
                    scnt_d  = 8'd1;
                end
            end
            REL_WAIT: begin
                if (valid) begin
                    state_d = HELD;
                end else begin
                    scnt_d = scnt_inc;
                    if (scnt_inc == DEB_C) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry/status next state; clr wins over a same-edge accept.
    always_comb begin
        kcode_ext      = '0;
        kcode_ext[3:0] = kcode_q;
        entry_d        = entry_q;
        count_d        = count_q;
        full_d         = full_q;
        ovf_d          = ovf_q;
        if (clr) begin
            entry_d = '0;
            count_d = 4'd0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            if (count_q < NDIG_C) begin
                entry_d = (entry_q << 4) | kcode_ext;
                count_d = count_q + 4'd1;
                full_d  = ((count_q + 4'd1) == NDIG_C);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Entry/status registers; strobe pulses on accept even when clr discards it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q  <= '0;
            count_q  <= 4'd0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            entry_q  <= entry_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            strobe_q <= accept;
        end
    end

    assign entry      = entry_q;
    assign count      = count_q;
    assign full       = full_q;
    assign ovf        = ovf_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Bench for bcd_key_entry: phase table of constant inputs held for N cycles.
// Expected accept edges go into a queue when a phase is driven; a negedge
// monitor pops them and checks key_strobe every cycle. Entry/status are
// checked at the end of flagged phases.
module tb_bcd_key_entry;

    logic        clk = 1'b0;
    logic        rst_n, chk, clr;
    logic [3:0]  digit;
    logic [15:0] entry;
    logic [3:0]  count;
    logic        full, ovf, key_strobe;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int exp_q[$];

    typedef struct {
        string       name;
        bit          rst_n;
        bit          chk;
        logic [3:0]  digit;
        bit          clr;
        int          n;       // cycles to hold these inputs
        int          sofs;    // edge offset of expected accept in this phase, -1 none
        bit          chk_st;  // check entry/status at end of phase
        logic [15:0] entry;
        logic [3:0]  count;
        bit          full;
        bit          ovf;
    } vec_t;

    vec_t vecs[$];

    bcd_key_entry #(.DEB_CYCLES(4), .NDIG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .chk        (chk),
        .digit      (digit),
        .clr        (clr),
        .entry      (entry),
        .count      (count),
        .full       (full),
        .ovf        (ovf),
        .key_strobe (key_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Strobe scoreboard: one check per cycle.
    always @(negedge clk) begin
        bit exp_s;
        exp_s = (exp_q.size() > 0 && exp_q[0] == edge_cnt);
        if (exp_s) void'(exp_q.pop_front());
        checks++;
        if (key_strobe !== exp_s) begin
            errors++;
            $display("FAIL strobe @edge %0d: got %b expected %b", edge_cnt, key_strobe, exp_s);
        end
    end

    task automatic add(string nm, bit r, bit c, logic [3:0] d, bit cl, int n, int so,
                       bit cs = 0, logic [15:0] e = 16'h0, logic [3:0] cn = 4'd0,
                       bit f = 0, bit o = 0);
        vec_t v;
        v.name = nm; v.rst_n = r; v.chk = c; v.digit = d; v.clr = cl; v.n = n;
        v.sofs = so; v.chk_st = cs; v.entry = e; v.count = cn; v.full = f; v.ovf = o;
        vecs.push_back(v);
    endtask

    task automatic rel(int n = 10);
        add("release", 1, 0, 4'd0, 0, n, -1);
    endtask

    initial begin
        // Key held through reset must debounce again afterwards.
        add("post_reset_press", 1, 1, 4'd5, 0, 6, 3, 1, 16'h0005, 4'd1, 0, 0);
        rel();
        add("clr0", 1, 0, 4'd0, 1, 1, -1, 1, 16'h0000, 4'd0, 0, 0);
        // Clean presses 1,9,0,7 then an overflow press.
        add("press1", 1, 1, 4'd1, 0, 10, 3, 1, 16'h0001, 4'd1, 0, 0); rel();
        add("press9", 1, 1, 4'd9, 0, 10, 3, 1, 16'h0019, 4'd2, 0, 0); rel();
        add("press0", 1, 1, 4'd0, 0, 10, 3, 1, 16'h0190, 4'd3, 0, 0); rel();
        add("press7", 1, 1, 4'd7, 0, 10, 3, 1, 16'h1907, 4'd4, 1, 0); rel();
        add("press3_ovf", 1, 1, 4'd3, 0, 10, 3, 1, 16'h1907, 4'd4, 1, 1); rel();
        add("clr1", 1, 0, 4'd0, 1, 1, -1, 1, 16'h0000, 4'd0, 0, 0);
        // Press bounce 1,0,1,0 then stable 4.
        add("bnc_a", 1, 1, 4'd4, 0, 1, -1);
        add("bnc_b", 1, 0, 4'd4, 0, 1, -1);
        add("bnc_c", 1, 1, 4'd4, 0, 1, -1);
        add("bnc_d", 1, 0, 4'd4, 0, 1, -1);
        add("bnc_hold4", 1, 1, 4'd4, 0, 8, 3, 1, 16'h0004, 4'd1, 0, 0);
        // Release bounce 0,1,0.
        add("rbnc_a", 1, 0, 4'd4, 0, 1, -1);
        add("rbnc_b", 1, 1, 4'd4, 0, 1, -1);
        add("rbnc_c", 1, 0, 4'd4, 0, 10, -1, 1, 16'h0004, 4'd1, 0, 0);
        // Digit change during press, then change while held.
        add("chg_2", 1, 1, 4'd2, 0, 2, -1);
        add("chg_6", 1, 1, 4'd6, 0, 8, 3, 1, 16'h0046, 4'd2, 0, 0);
        add("held_8", 1, 1, 4'd8, 0, 6, -1, 1, 16'h0046, 4'd2, 0, 0);
        rel();
        // Invalid code is ignored.
        add("code_C", 1, 1, 4'hC, 0, 20, -1, 1, 16'h0046, 4'd2, 0, 0);
        // clr collides with the accept edge of digit 5.
        add("pre_5", 1, 1, 4'd5, 0, 3, -1);
        add("clr_coll", 1, 1, 4'd5, 1, 1, 0, 1, 16'h0000, 4'd0, 0, 0);
        add("hold_5", 1, 1, 4'd5, 0, 3, -1, 1, 16'h0000, 4'd0, 0, 0);
        rel();
        // Fill, overflow, then clr everything.
        add("f1", 1, 1, 4'd1, 0, 8, 3); rel(8);
        add("f2", 1, 1, 4'd2, 0, 8, 3); rel(8);
        add("f3", 1, 1, 4'd3, 0, 8, 3); rel(8);
        add("f4", 1, 1, 4'd4, 0, 8, 3, 1, 16'h1234, 4'd4, 1, 0); rel(8);
        add("f8_ovf", 1, 1, 4'd8, 0, 8, 3, 1, 16'h1234, 4'd4, 1, 1); rel(8);
        add("clr_full", 1, 0, 4'd0, 1, 1, -1, 1, 16'h0000, 4'd0, 0, 0);
        // Reset mid-hold clears state; the held key is re-debounced.
        add("pre_rst7", 1, 1, 4'd7, 0, 8, 3, 1, 16'h0007, 4'd1, 0, 0);
        add("rst_held", 0, 1, 4'd7, 1, 2, -1, 1, 16'h0000, 4'd0, 0, 0);
        add("post_rst7", 1, 1, 4'd7, 0, 6, 3, 1, 16'h0007, 4'd1, 0, 0);
        rel();

        // Hand-written reset sequence with a key held.
        rst_n = 1'b0; chk = 1'b1; digit = 4'd5; clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({entry, count, full, ovf, key_strobe} !== 26'd0) begin
                errors++;
                $display("FAIL reset_cycle%0d: got entry=%h count=%0d full=%b ovf=%b strobe=%b expected all 0",
                         i, entry, count, full, ovf, key_strobe);
            end
        end

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; chk = vecs[i].chk; digit = vecs[i].digit; clr = vecs[i].clr;
            if (vecs[i].sofs >= 0) exp_q.push_back(edge_cnt + 1 + vecs[i].sofs);
            repeat (vecs[i].n) @(negedge clk);
            if (vecs[i].chk_st) begin
                checks++;
                if ({entry, count, full, ovf} !== {vecs[i].entry, vecs[i].count, vecs[i].full, vecs[i].ovf}) begin
                    errors++;
                    $display("FAIL %s: got entry=%h count=%0d full=%b ovf=%b expected entry=%h count=%0d full=%b ovf=%b",
                             vecs[i].name, entry, count, full, ovf,
                             vecs[i].entry, vecs[i].count, vecs[i].full, vecs[i].ovf);
                end
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_strobes: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
